// File: rtl/letc_core_decode_stage.sv
// letc_core_decode_stage
//   Registered RV32/RV64 decode stage between fetch and execute. Each accepted
//   instruction is classified by its major opcode, and its register indices,
//   funct3 and sign-extended immediate are extracted. An illegal-instruction
//   flag is raised for encodings this configuration does not implement.
//   Illegal bundles are delivered like any other bundle. A main register plus
//   a skid register give full throughput with a registered o_inst_ready.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_flush               drop everything held in the stage
//   i_inst_valid/o_inst_ready, i_inst, i_pc        upstream handshake and payload
//   o_dec_valid/i_dec_ready                        downstream handshake
//   o_dec_opcode/rd/rs1/rs2/funct3/imm/pc/illegal  decoded bundle (main register)
module letc_core_decode_stage #(
  parameter int XLEN      = 32,
  parameter int SUPPORT_A = 0,
  parameter int SUPPORT_F = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_dec_valid,
  input  logic            i_dec_ready,
  output logic [4:0]      o_dec_opcode,
  output logic [4:0]      o_dec_rd,
  output logic [4:0]      o_dec_rs1,
  output logic [4:0]      o_dec_rs2,
  output logic [2:0]      o_dec_funct3,
  output logic [XLEN-1:0] o_dec_imm,
  output logic [XLEN-1:0] o_dec_pc,
  output logic            o_dec_illegal
);

  typedef enum logic [4:0] {
    LOAD     = 5'b00000, LOAD_FP  = 5'b00001, CUSTOM_0 = 5'b00010, MISC_MEM = 5'b00011,
    OP_IMM   = 5'b00100, AUIPC    = 5'b00101, OP_IMM_32 = 5'b00110, B48_0  = 5'b00111,
    STORE    = 5'b01000, STORE_FP = 5'b01001, CUSTOM_1 = 5'b01010, AMO      = 5'b01011,
    OP       = 5'b01100, LUI      = 5'b01101, OP_32    = 5'b01110, B64      = 5'b01111,
    MADD     = 5'b10000, MSUB     = 5'b10001, NMSUB    = 5'b10010, NMADD    = 5'b10011,
    OP_FP    = 5'b10100, RESERVED_10101 = 5'b10101, CUSTOM_2 = 5'b10110, B48_1 = 5'b10111,
    BRANCH   = 5'b11000, JALR     = 5'b11001, RESERVED_11010 = 5'b11010, JAL = 5'b11011,
    SYSTEM   = 5'b11100, RESERVED_11101 = 5'b11101, CUSTOM_3 = 5'b11110, BGE80 = 5'b11111
  } opcode_e;

  typedef struct packed {
    logic [4:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  opcode_e     op;
  logic [31:0] imm32;
  logic        illegal;
  bundle_t     dec, main_q, skid_q;
  logic        main_vld, skid_vld;
  logic        accept, send;

  // Combinational decode of the incoming word.
  always_comb begin
    op    = opcode_e'(i_inst[6:2]);
    imm32 = '0;
    case (op)
      LOAD, LOAD_FP, OP_IMM, OP_IMM_32, JALR, SYSTEM:
        imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      STORE, STORE_FP:
        imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      BRANCH:
        imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      LUI, AUIPC:
        imm32 = {i_inst[31:12], 12'b0};
      JAL:
        imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    // Compressed-space words (bits[1:0] != 11) are never legal here.
    illegal = (i_inst[1:0] != 2'b11);
    case (op)
      CUSTOM_0, CUSTOM_1, CUSTOM_2, CUSTOM_3,
      RESERVED_10101, RESERVED_11010, RESERVED_11101,
      B48_0, B48_1, B64, BGE80:
        illegal = 1'b1;
      OP_IMM_32, OP_32:
        if (XLEN != 64) illegal = 1'b1;
      AMO:
        if (SUPPORT_A == 0) illegal = 1'b1;
      LOAD_FP, STORE_FP, OP_FP, MADD, MSUB, NMSUB, NMADD:
        if (SUPPORT_F == 0) illegal = 1'b1;
      default: ;
    endcase

    dec.opcode  = i_inst[6:2];
    dec.rd      = i_inst[11:7];
    dec.rs1     = i_inst[19:15];
    dec.rs2     = i_inst[24:20];
    dec.funct3  = i_inst[14:12];
    dec.imm     = XLEN'($signed(imm32));
    dec.pc      = i_pc;
    dec.illegal = illegal;
  end

  // Ready depends only on skid occupancy, so it never combinationally follows i_dec_ready.
  assign o_inst_ready = !skid_vld;
  assign accept       = i_inst_valid & o_inst_ready;
  assign send         = main_vld & i_dec_ready;

  // skid_vld implies main_vld: skid only fills while main is being held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (i_flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (send) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= dec;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (main_vld) begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end else begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end
    end
  end

  assign o_dec_valid   = main_vld;
  assign o_dec_opcode  = main_q.opcode;
  assign o_dec_rd      = main_q.rd;
  assign o_dec_rs1     = main_q.rs1;
  assign o_dec_rs2     = main_q.rs2;
  assign o_dec_funct3  = main_q.funct3;
  assign o_dec_imm     = main_q.imm;
  assign o_dec_pc      = main_q.pc;
  assign o_dec_illegal = main_q.illegal;

endmodule

// File: tb/tb_letc_core_decode_stage.sv
// Bench for letc_core_decode_stage: one RV32 instance (no A/F) and one RV64
// instance (A and F enabled) share all stimulus. Directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_letc_core_decode_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_v, dec_rdy;
  logic [31:0] inst;
  logic [63:0] pc;

  logic        r32, v32, il32;
  logic [4:0]  op32, rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [31:0] imm32, pc32;
  logic        r64, v64, il64;
  logic [4:0]  op64, rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [63:0] imm64, pc64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  letc_core_decode_stage #(.XLEN(32), .SUPPORT_A(0), .SUPPORT_F(0)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_inst_valid(in_v), .o_inst_ready(r32),
    .i_inst(inst), .i_pc(pc[31:0]), .o_dec_valid(v32), .i_dec_ready(dec_rdy),
    .o_dec_opcode(op32), .o_dec_rd(rd32), .o_dec_rs1(rs1_32), .o_dec_rs2(rs2_32),
    .o_dec_funct3(f3_32), .o_dec_imm(imm32), .o_dec_pc(pc32), .o_dec_illegal(il32));

  letc_core_decode_stage #(.XLEN(64), .SUPPORT_A(1), .SUPPORT_F(1)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_inst_valid(in_v), .o_inst_ready(r64),
    .i_inst(inst), .i_pc(pc), .o_dec_valid(v64), .i_dec_ready(dec_rdy),
    .o_dec_opcode(op64), .o_dec_rd(rd64), .o_dec_rs1(rs1_64), .o_dec_rs2(rs2_64),
    .o_dec_funct3(f3_64), .o_dec_imm(imm64), .o_dec_pc(pc64), .o_dec_illegal(il64));

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    int op = int'(w[6:2]);
    longint v = 0;
    if (op inside {0, 1, 4, 6, 25, 28}) v = longint'($signed(w[31:20]));
    else if (op inside {8, 9})          v = longint'($signed({w[31:25], w[11:7]}));
    else if (op == 24)                  v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    else if (op inside {5, 13})         v = longint'($signed({w[31:12], 12'h000}));
    else if (op == 27)                  v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    return v;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w, input bit rv64, input bit has_a,
                                       input bit has_f);
    int op = int'(w[6:2]);
    if (w[1:0] != 2'b11) return 1'b1;
    if (op inside {2, 10, 22, 30, 21, 26, 29, 7, 23, 15, 31}) return 1'b1;
    if (!rv64 && op inside {6, 14}) return 1'b1;
    if (!has_a && op == 11) return 1'b1;
    if (!has_f && op inside {1, 9, 16, 17, 18, 19, 20}) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct { logic [31:0] w; logic [63:0] p; } item_t;

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] p);
    in_v = v; inst = w; pc = p;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; dec_rdy = 1'b0; drive(1'b0, 32'h0, 64'h0);
    step(); step();
    vectors++;
    if ({v32, v64, r32, r64} !== 4'b0011) begin
      miscompares++; $display("FAIL reset_hs: valid32/64,ready32/64=%b want 0011", {v32, v64, r32, r64});
    end
    vectors++;
    if ({op32, rd32, rs1_32, rs2_32, f3_32, imm32, pc32, il32} !== '0 ||
        {op64, rd64, rs1_64, rs2_64, f3_64, imm64, pc64, il64} !== '0) begin
      miscompares++; $display("FAIL reset_data: imm32=%h pc32=%h imm64=%h pc64=%h want 0", imm32, pc32, imm64, pc64);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    dec_rdy = 1'b1;
    drive(1'b1, 32'hFFF30293, 64'h100);
    step();
    drive(1'b0, 32'h0, 64'h0);
    vectors++;
    if ({v32, op32, rd32, rs1_32, imm32, pc32, il32} !== {1'b1, 5'd4, 5'd5, 5'd6, 32'hFFFFFFFF, 32'h100, 1'b0}) begin
      miscompares++; $display("FAIL addi32: v=%b op=%0d rd=%0d rs1=%0d imm=%h pc=%h ill=%b want 1/4/5/6/ffffffff/100/0",
                              v32, op32, rd32, rs1_32, imm32, pc32, il32);
    end
    vectors++;
    if ({v64, op64, rd64, rs1_64, imm64, pc64, il64} !== {1'b1, 5'd4, 5'd5, 5'd6, 64'hFFFFFFFF_FFFFFFFF, 64'h100, 1'b0}) begin
      miscompares++; $display("FAIL addi64: v=%b op=%0d rd=%0d rs1=%0d imm=%h pc=%h ill=%b want all-ones imm",
                              v64, op64, rd64, rs1_64, imm64, pc64, il64);
    end
    step();
    vectors++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      miscompares++; $display("FAIL addi_drain: valid=%b/%b want 0", v32, v64);
    end
  endtask

  task automatic test_skid();
    logic [31:0] ws [3];
    ws[0] = 32'h00100093; ws[1] = 32'h00200113; ws[2] = 32'h00300193;
    dec_rdy = 1'b0;
    drive(1'b1, ws[0], 64'h10); step();
    vectors++;
    if (r32 !== 1'b1 || r64 !== 1'b1) begin
      miscompares++; $display("FAIL skid_ready1: ready=%b/%b want 1", r32, r64);
    end
    drive(1'b1, ws[1], 64'h14); step();
    vectors++;
    if (r32 !== 1'b0 || r64 !== 1'b0) begin
      miscompares++; $display("FAIL skid_ready2: ready=%b/%b want 0", r32, r64);
    end
    drive(1'b1, ws[2], 64'h18); step();
    drive(1'b0, 32'h0, 64'h0);
    vectors++;
    if ({v32, rd32, pc32, r32} !== {1'b1, 5'd1, 32'h10, 1'b0}) begin
      miscompares++; $display("FAIL skid_hold: v=%b rd=%0d pc=%h ready=%b want 1/1/10/0", v32, rd32, pc32, r32);
    end
    dec_rdy = 1'b1;
    step();
    vectors++;
    if ({v32, rd32, pc32, v64, rd64} !== {1'b1, 5'd2, 32'h14, 1'b1, 5'd2}) begin
      miscompares++; $display("FAIL skid_second: v=%b rd=%0d pc=%h rd64=%0d want 1/2/14/2", v32, rd32, pc32, rd64);
    end
    step();
    vectors++;
    if (v32 !== 1'b0 || v64 !== 1'b0 || r32 !== 1'b1) begin
      miscompares++; $display("FAIL skid_no_third: valid=%b/%b ready=%b want 0/0/1", v32, v64, r32);
    end
  endtask

  task automatic test_imm();
    logic [31:0] ws [3];
    logic [31:0] e32 [3];
    logic [63:0] e64 [3];
    ws[0] = 32'hFE000EE3; e32[0] = 32'hFFFFFFFC; e64[0] = 64'hFFFFFFFF_FFFFFFFC;
    ws[1] = 32'h0040006F; e32[1] = 32'h00000004; e64[1] = 64'h4;
    ws[2] = 32'h800000B7; e32[2] = 32'h80000000; e64[2] = 64'hFFFFFFFF_80000000;
    dec_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ws[i], 64'h400 + 64'(4 * i)); step();
      drive(1'b0, 32'h0, 64'h0);
      vectors++;
      if (v32 !== 1'b1 || imm32 !== e32[i] || il32 !== 1'b0) begin
        miscompares++; $display("FAIL imm32[%0d]: v=%b imm=%h ill=%b want 1/%h/0", i, v32, imm32, il32, e32[i]);
      end
      vectors++;
      if (v64 !== 1'b1 || imm64 !== e64[i] || il64 !== 1'b0) begin
        miscompares++; $display("FAIL imm64[%0d]: v=%b imm=%h ill=%b want 1/%h/0", i, v64, imm64, il64, e64[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ws [5];
    logic [1:0]  ex [5];  // {rv32 expectation, rv64 expectation}
    ws[0] = 32'h0010809B; ex[0] = 2'b10;  // addiw
    ws[1] = 32'h00000010; ex[1] = 2'b11;  // bits[1:0] = 00
    ws[2] = 32'h0000202F; ex[2] = 2'b10;  // AMO
    ws[3] = 32'h00002007; ex[3] = 2'b10;  // flw
    ws[4] = 32'h0000000B; ex[4] = 2'b11;  // custom-0
    dec_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ws[i], 64'h800); step();
      drive(1'b0, 32'h0, 64'h0);
      vectors++;
      if ({v32, v64, il32, il64} !== {2'b11, ex[i]}) begin
        miscompares++; $display("FAIL illegal[%0d] %h: valid=%b%b ill32/64=%b%b want 11/%b", i, ws[i], v32, v64, il32, il64, ex[i]);
      end
      step();
    end
  endtask

  task automatic test_flush();
    dec_rdy = 1'b0;
    drive(1'b1, 32'h00100093, 64'h20); step();
    drive(1'b1, 32'h00200113, 64'h24); step();
    vectors++;
    if (r32 !== 1'b0 || v32 !== 1'b1) begin
      miscompares++; $display("FAIL flush_full: ready=%b valid=%b want 0/1", r32, v32);
    end
    flush = 1'b1; drive(1'b1, 32'h00700393, 64'h28); step();
    flush = 1'b0; drive(1'b0, 32'h0, 64'h0);
    vectors++;
    if ({v32, v64, r32, r64} !== 4'b0011) begin
      miscompares++; $display("FAIL flush_full_clear: valid/ready=%b want 0011", {v32, v64, r32, r64});
    end
    // Flush in a cycle where an accept happens: that instruction is discarded.
    flush = 1'b1; drive(1'b1, 32'h00700393, 64'h2C); step();
    flush = 1'b0; drive(1'b0, 32'h0, 64'h0);
    vectors++;
    if ({v32, v64, r32, r64} !== 4'b0011) begin
      miscompares++; $display("FAIL flush_accept: valid/ready=%b want 0011", {v32, v64, r32, r64});
    end
    dec_rdy = 1'b1;
    drive(1'b1, 32'h00400213, 64'h30); step();
    drive(1'b0, 32'h0, 64'h0);
    vectors++;
    if ({v32, rd32, pc32, v64, rd64} !== {1'b1, 5'd4, 32'h30, 1'b1, 5'd4}) begin
      miscompares++; $display("FAIL flush_after: v=%b rd=%0d pc=%h rd64=%0d want 1/4/30/4", v32, rd32, pc32, rd64);
    end
    step();
    vectors++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      miscompares++; $display("FAIL flush_ghost: valid=%b/%b want 0", v32, v64);
    end
  endtask

  task automatic test_async_reset();
    dec_rdy = 1'b0;
    drive(1'b1, 32'hFE000EE3, 64'h50); step();
    drive(1'b1, 32'h800000B7, 64'h54); step();
    drive(1'b0, 32'h0, 64'h0);
    #2 rst = 1'b1;
    #1;  // mid-cycle, no clock edge since reset rose
    vectors++;
    if ({v32, v64, r32, r64} !== 4'b0011) begin
      miscompares++; $display("FAIL arst_hs: valid/ready=%b want 0011", {v32, v64, r32, r64});
    end
    vectors++;
    if ({op32, rd32, rs1_32, rs2_32, f3_32, imm32, pc32, il32} !== '0 ||
        {op64, rd64, rs1_64, rs2_64, f3_64, imm64, pc64, il64} !== '0) begin
      miscompares++; $display("FAIL arst_data: imm32=%h pc32=%h imm64=%h pc64=%h want 0", imm32, pc32, imm64, pc64);
    end
    step(); step();
    rst = 1'b0;
    dec_rdy = 1'b1;
    drive(1'b1, 32'hFFF30293, 64'h200); step();
    drive(1'b0, 32'h0, 64'h0);
    vectors++;
    if ({v32, op32, rd32, rs1_32, imm32, pc32, il32} !== {1'b1, 5'd4, 5'd5, 5'd6, 32'hFFFFFFFF, 32'h200, 1'b0}) begin
      miscompares++; $display("FAIL arst_first: v=%b op=%0d rd=%0d rs1=%0d imm=%h pc=%h ill=%b", v32, op32, rd32, rs1_32, imm32, pc32, il32);
    end
    step();
  endtask

  task automatic test_random();
    item_t       q[$];
    item_t       it;
    logic [31:0] w;
    logic [63:0] im;
    logic        exp_v, exp_r;
    // Start from a known-empty stage.
    flush = 1'b1; drive(1'b0, 32'h0, 64'h0); step(); flush = 1'b0;
    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[1:0] = 2'b11;
      drive(1'($urandom_range(0, 9) < 7), w, {$urandom, $urandom});
      dec_rdy = 1'($urandom_range(0, 9) < 6);
      flush   = 1'($urandom_range(0, 19) == 0);
      @(negedge clk);
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      vectors++;
      if ({v32, v64, r32, r64} !== {exp_v, exp_v, exp_r, exp_r}) begin
        miscompares++; $display("FAIL rand_hs[%0d]: valid/ready=%b want %b%b%b%b", n, {v32, v64, r32, r64}, exp_v, exp_v, exp_r, exp_r);
      end
      if (exp_v) begin
        it = q[0];
        im = ref_imm(it.w);
        vectors++;
        if ({op32, rd32, rs1_32, rs2_32, f3_32, il32, imm32, pc32} !==
            {it.w[6:2], it.w[11:7], it.w[19:15], it.w[24:20], it.w[14:12],
             ref_illegal(it.w, 1'b0, 1'b0, 1'b0), im[31:0], it.p[31:0]}) begin
          miscompares++; $display("FAIL rand32[%0d] inst=%h: op=%0d rd=%0d ill=%b imm=%h pc=%h want ill=%b imm=%h pc=%h",
                                  n, it.w, op32, rd32, il32, imm32, pc32, ref_illegal(it.w, 1'b0, 1'b0, 1'b0), im[31:0], it.p[31:0]);
        end
        vectors++;
        if ({op64, rd64, rs1_64, rs2_64, f3_64, il64, imm64, pc64} !==
            {it.w[6:2], it.w[11:7], it.w[19:15], it.w[24:20], it.w[14:12],
             ref_illegal(it.w, 1'b1, 1'b1, 1'b1), im, it.p}) begin
          miscompares++; $display("FAIL rand64[%0d] inst=%h: op=%0d rd=%0d ill=%b imm=%h pc=%h want ill=%b imm=%h pc=%h",
                                  n, it.w, op64, rd64, il64, imm64, pc64, ref_illegal(it.w, 1'b1, 1'b1, 1'b1), im, it.p);
        end
      end
      if (exp_v && dec_rdy) void'(q.pop_front());
      if (in_v && exp_r) begin
        it.w = inst; it.p = pc;
        q.push_back(it);
      end
      if (flush) q.delete();
      step();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_skid();
    test_imm();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end
endmodule
